// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, registered wrap and load-error pulses.
// One-cycle latency from any input to bcd/flags; no backpressure, a step is taken on every enabled edge.
module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] bcd_q;
  logic [W-1:0] step_dat;
  logic         step_wrap;
  logic         load_ok;
  logic         wrap_q;
  logic         load_err_q;

  // Ripple carry/borrow across all digits; a carry out of the top digit is a wrap.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    step_dat = bcd_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (dig == 4'd9) begin
            step_dat[4*i +: 4] = 4'd0;
          end else begin
            step_dat[4*i +: 4] = dig + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_dat[4*i +: 4] = 4'd9;
          end else begin
            step_dat[4*i +: 4] = dig - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // A rejected load leaves the count untouched so bcd never holds an illegal digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        bcd_q <= load_val;
      end
      wrap_q     <= 1'b0;
      load_err_q <= ~load_ok;
    end else if (en) begin
      bcd_q      <= step_dat;
      wrap_q     <= step_wrap;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end
  end

  assign bcd      = bcd_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
